// File: rtl/collision_pkg.sv
// rtl/collision_pkg.sv - shared types and constants for the collision sensor
package collision_pkg;

    localparam int unsigned FLOOR_Y    = 360;
    localparam int unsigned PLAYER_W   = 16;
    localparam int unsigned PLAYER_H   = 16;
    localparam int unsigned GROUND_TOL = 8;
    localparam int unsigned WALL_TOL   = 3;

    // One platform rectangle [l,r) x [t,b); valid=0 entries are skipped
    typedef struct packed {
        logic       valid;
        logic [9:0] l;
        logic [9:0] r;
        logic [9:0] t;
        logic [9:0] b;
    } plat_t;

    localparam int unsigned PLAT_BITS = $bits(plat_t);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Zero-extend a 10-bit coordinate so sums with the size constants cannot wrap
    function automatic logic [10:0] ext11(input logic [9:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/collision_sensor_platform_rom.sv
// rtl/collision_sensor_platform_rom.sv - constant platform table lookup
module platform_rom
    import collision_pkg::*;
(
    input  logic [3:0]           idx,
    output logic [PLAT_BITS-1:0] entry
);

    // Level layout: two platforms, remaining slots empty
    always_comb begin
        entry = '0;
        case (idx)
            4'd0:    entry = {1'b1, 10'd100, 10'd160, 10'd300, 10'd316};
            4'd1:    entry = {1'b1, 10'd200, 10'd260, 10'd330, 10'd346};
            default: entry = '0;
        endcase
    end

endmodule

// File: rtl/collision_sensor.sv
// rtl/collision_sensor.sv - per-tick platform scan producing contact flags
module collision_sensor
    import collision_pkg::*;
#(
    parameter int NUM_PLAT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_tick,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic       on_ground,
    output logic [9:0] support_y,
    output logic       hit_ceiling,
    output logic       hit_left_wall,
    output logic       hit_right_wall,
    output logic       scan_done,
    output logic       overrun
);

    localparam logic [10:0] PW   = 11'(PLAYER_W);
    localparam logic [10:0] PH   = 11'(PLAYER_H);
    localparam logic [10:0] GT   = 11'(GROUND_TOL);
    localparam logic [10:0] WT   = 11'(WALL_TOL);
    localparam logic [10:0] FY   = 11'(FLOOR_Y);
    localparam logic [3:0]  LAST = 4'(NUM_PLAT - 1);

    state_t state, next_state;

    logic [3:0]  idx;
    logic [9:0]  px_q, py_q;
    logic        acc_ground, acc_ceil, acc_left, acc_right;
    logic [9:0]  acc_sup;

    logic [PLAT_BITS-1:0] entry_bits;
    plat_t                entry;

    logic [10:0] px11, py11, feet, px_right;
    logic [10:0] l11, r11, t11, b11;
    logic        hov, vov, e_ground, e_ceil, e_left, e_right, floor_ground;
    logic        m_ground, m_ceil, m_left, m_right;
    logic [9:0]  m_sup;

    platform_rom u_rom (
        .idx   (idx),
        .entry (entry_bits)
    );

    assign entry = plat_t'(entry_bits);

    // Per-entry geometric tests on the snapshot, merged into the running accumulators
    always_comb begin
        px11     = ext11(px_q);
        py11     = ext11(py_q);
        feet     = py11 + PH;
        px_right = px11 + PW;
        l11      = ext11(entry.l);
        r11      = ext11(entry.r);
        t11      = ext11(entry.t);
        b11      = ext11(entry.b);

        hov      = (px_right > l11) && (px11 < r11);
        vov      = (feet > t11) && (py11 < b11);
        e_ground = entry.valid && hov && (feet >= t11) && (feet <= t11 + GT);
        e_ceil   = entry.valid && hov && (py11 > t11) && (py11 <= b11);
        e_left   = entry.valid && vov && (r11 <= px11) && (px11 <= r11 + WT);
        e_right  = entry.valid && vov && (px_right <= l11) && (l11 <= px_right + WT);
        floor_ground = (feet >= FY);

        m_ceil   = acc_ceil  | e_ceil;
        m_left   = acc_left  | e_left;
        m_right  = acc_right | e_right;
        m_ground = acc_ground | e_ground;
        m_sup    = acc_sup;
        if (e_ground && (entry.t < m_sup)) begin
            m_sup = entry.t;
        end
        // The floor only counts on the final merge so it is applied exactly once
        if ((idx == LAST) && floor_ground) begin
            m_ground = 1'b1;
            if (10'(FLOOR_Y) < m_sup) begin
                m_sup = 10'(FLOOR_Y);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (game_tick) next_state = SCAN;
            SCAN:    if (idx == LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs: done pulse in DONE, overrun when a tick lands on a busy scan
    always_comb begin
        scan_done = (state == DONE);
        overrun   = rst && game_tick && (state != IDLE);
    end

    // Snapshot, index, accumulators and committed outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx            <= '0;
            px_q           <= '0;
            py_q           <= '0;
            acc_ground     <= 1'b0;
            acc_ceil       <= 1'b0;
            acc_left       <= 1'b0;
            acc_right      <= 1'b0;
            acc_sup        <= '1;
            on_ground      <= 1'b1;
            support_y      <= 10'(FLOOR_Y);
            hit_ceiling    <= 1'b0;
            hit_left_wall  <= 1'b0;
            hit_right_wall <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (game_tick) begin
                        px_q       <= player_x;
                        py_q       <= player_y;
                        idx        <= '0;
                        acc_ground <= 1'b0;
                        acc_ceil   <= 1'b0;
                        acc_left   <= 1'b0;
                        acc_right  <= 1'b0;
                        acc_sup    <= '1;
                    end
                end
                SCAN: begin
                    if (idx == LAST) begin
                        on_ground      <= m_ground;
                        hit_ceiling    <= m_ceil;
                        hit_left_wall  <= m_left;
                        hit_right_wall <= m_right;
                        if (m_ground) begin
                            support_y <= m_sup;
                        end
                    end else begin
                        idx        <= idx + 4'd1;
                        acc_ground <= m_ground;
                        acc_ceil   <= m_ceil;
                        acc_left   <= m_left;
                        acc_right  <= m_right;
                        acc_sup    <= m_sup;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collision_sensor.sv
// tb/tb_collision_sensor.sv - self-checking bench for collision_sensor
module tb_collision_sensor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       game_tick = 1'b0;
    logic [9:0] player_x = '0;
    logic [9:0] player_y = '0;
    logic       on_ground, hit_ceiling, hit_left_wall, hit_right_wall;
    logic       scan_done, overrun;
    logic [9:0] support_y;

    collision_sensor #(.NUM_PLAT(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .game_tick      (game_tick),
        .player_x       (player_x),
        .player_y       (player_y),
        .on_ground      (on_ground),
        .support_y      (support_y),
        .hit_ceiling    (hit_ceiling),
        .hit_left_wall  (hit_left_wall),
        .hit_right_wall (hit_right_wall),
        .scan_done      (scan_done),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int g;
        int sup;
        int c;
        int lw;
        int rw;
    } res_t;

    typedef struct {
        int px;
        int py;
        res_t exp;
    } vec_t;

    typedef struct {
        int l;
        int r;
        int t;
        int b;
    } rect_t;

    int    total = 0;
    int    bad = 0;
    rect_t plats[2];
    vec_t  vecs[9];
    res_t  got;
    res_t  snap;
    int    model_sup;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference: contact rules evaluated directly over the list of real platforms
    function automatic res_t model(input int px, input int py, input int prev_sup);
        res_t r;
        int   feet;
        int   best;
        int   pr;
        r.g = 0; r.sup = prev_sup; r.c = 0; r.lw = 0; r.rw = 0;
        feet = py + 16;
        pr   = px + 16;
        best = 1 << 20;
        if (feet >= 360) begin
            r.g  = 1;
            best = 360;
        end
        foreach (plats[i]) begin
            bit horiz, vert;
            horiz = (pr > plats[i].l) && (px < plats[i].r);
            vert  = (feet > plats[i].t) && (py < plats[i].b);
            if (horiz && feet >= plats[i].t && feet <= plats[i].t + 8) begin
                r.g = 1;
                if (plats[i].t < best) best = plats[i].t;
            end
            if (horiz && py > plats[i].t && py <= plats[i].b) r.c = 1;
            if (vert && plats[i].r <= px && px <= plats[i].r + 3) r.lw = 1;
            if (vert && pr <= plats[i].l && plats[i].l <= pr + 3) r.rw = 1;
        end
        if (r.g != 0) r.sup = best;
        return r;
    endfunction

    function automatic res_t mk(input int g, input int sup, input int c, input int lw, input int rw);
        res_t r;
        r.g = g; r.sup = sup; r.c = c; r.lw = lw; r.rw = rw;
        return r;
    endfunction

    task automatic sample_outputs(output res_t r);
        r.g   = int'(on_ground);
        r.sup = int'(support_y);
        r.c   = int'(hit_ceiling);
        r.lw  = int'(hit_left_wall);
        r.rw  = int'(hit_right_wall);
    endtask

    task automatic check_res(input string tag, input res_t a, input res_t e);
        check({tag, ".on_ground"}, a.g, e.g);
        check({tag, ".support_y"}, a.sup, e.sup);
        check({tag, ".hit_ceiling"}, a.c, e.c);
        check({tag, ".hit_left_wall"}, a.lw, e.lw);
        check({tag, ".hit_right_wall"}, a.rw, e.rw);
    endtask

    // Tick in cycle 0, optional second tick / reset at given cycles, observe 20 cycles
    task automatic run_scan(input int px, input int py, input int tick2_at, input int rst_at,
                            output int done_cycle, output int ndone,
                            output int ov_cycle, output int nov);
        done_cycle = -1; ndone = 0; ov_cycle = -1; nov = 0;
        @(posedge clk); #1;
        game_tick = 1'b1;
        player_x  = 10'(px);
        player_y  = 10'(py);
        #3;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            game_tick = (k == tick2_at);
            rst       = (k == rst_at) ? 1'b0 : 1'b1;
            #3;
            if (scan_done === 1'b1) begin
                ndone++;
                done_cycle = k;
                sample_outputs(got);
            end
            if (overrun === 1'b1) begin
                nov++;
                ov_cycle = k;
            end
            if (k == rst_at + 1) sample_outputs(snap);
        end
        game_tick = 1'b0;
    endtask

    initial begin
        int dc, nd, oc, no;
        res_t e;

        plats[0] = '{l: 100, r: 160, t: 300, b: 316};
        plats[1] = '{l: 200, r: 260, t: 330, b: 346};

        vecs[0] = '{px: 20,  py: 344, exp: mk(1, 360, 0, 0, 0)};
        vecs[1] = '{px: 120, py: 284, exp: mk(1, 300, 0, 0, 0)};
        vecs[2] = '{px: 120, py: 292, exp: mk(1, 300, 0, 0, 0)};
        vecs[3] = '{px: 120, py: 293, exp: mk(0, 300, 0, 0, 0)};
        vecs[4] = '{px: 120, py: 310, exp: mk(0, 300, 1, 0, 0)};
        vecs[5] = '{px: 163, py: 305, exp: mk(0, 300, 0, 1, 0)};
        vecs[6] = '{px: 164, py: 305, exp: mk(0, 300, 0, 0, 0)};
        vecs[7] = '{px: 181, py: 330, exp: mk(0, 300, 0, 0, 1)};
        vecs[8] = '{px: 180, py: 330, exp: mk(0, 300, 0, 0, 0)};

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #3;
        sample_outputs(got);
        check_res("reset", got, mk(1, 360, 0, 0, 0));
        check("reset.scan_done", scan_done, 1'b0);
        check("reset.overrun", overrun, 1'b0);

        // Directed table
        foreach (vecs[i]) begin
            run_scan(vecs[i].px, vecs[i].py, -1, -1, dc, nd, oc, no);
            check($sformatf("vec%0d.done_cycle", i), dc, 9);
            check($sformatf("vec%0d.done_count", i), nd, 1);
            check($sformatf("vec%0d.overrun_count", i), no, 0);
            check_res($sformatf("vec%0d", i), got, vecs[i].exp);
        end

        // Overrun: second tick in cycle 3 is ignored
        run_scan(20, 344, 3, -1, dc, nd, oc, no);
        check("ovr.overrun_cycle", oc, 3);
        check("ovr.overrun_count", no, 1);
        check("ovr.done_cycle", dc, 9);
        check("ovr.done_count", nd, 1);
        check_res("ovr", got, mk(1, 360, 0, 0, 0));

        // Leave non-reset outputs, then reset mid-scan
        run_scan(181, 330, -1, -1, dc, nd, oc, no);
        check_res("pre_rst", got, mk(0, 360, 0, 0, 1));
        run_scan(181, 330, 3, 4, dc, nd, oc, no);
        check("rst.overrun_cycle", oc, 3);
        check("rst.done_count", nd, 0);
        check_res("rst", snap, mk(1, 360, 0, 0, 0));
        model_sup = 360;

        // Randomized scans against the reference model
        for (int n = 0; n < 150; n++) begin
            int px, py;
            if (n % 2 == 0) begin
                px = $urandom_range(80, 280);
                py = $urandom_range(270, 370);
            end else begin
                px = $urandom_range(0, 1023);
                py = $urandom_range(0, 1023);
            end
            e = model(px, py, model_sup);
            run_scan(px, py, -1, -1, dc, nd, oc, no);
            check($sformatf("rnd%0d.done_cycle", n), dc, 9);
            check_res($sformatf("rnd%0d(px=%0d,py=%0d)", n, px, py), got, e);
            model_sup = e.sup;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
